// File: rtl/reg_pipe_pkg.sv
// -----------------------------------------------------------------------------
// reg_pipe_pkg
//   Shared definitions for the reg_pipeline retiming chain.
//   - occ_width(depth): bit width needed to count 0..depth valid stages.
//   - PAR_W: number of parity bits carried per stage (1 when REG_PIPE_PARITY_EN
//     is defined, 0 otherwise).
//   - stage_ctl_t: per-stage control record (valid, plus parity when enabled).
//     The data word is kept beside the record because its width is a
//     per-instance parameter.
// Optional feature macro: REG_PIPE_PARITY_EN
// -----------------------------------------------------------------------------
package reg_pipe_pkg;

`ifdef REG_PIPE_PARITY_EN
  localparam int PAR_W = 1;

  typedef struct packed {
    logic valid;
    logic par;
  } stage_ctl_t;
`else
  localparam int PAR_W = 0;

  typedef struct packed {
    logic valid;
  } stage_ctl_t;
`endif

  // Width of an occupancy counter able to represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    int w;
    w = 1;
    if (depth > 1) begin
      w = $clog2(depth + 1);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage : reg_pipe_pkg

// File: rtl/reg_pipeline_pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
//   One register stage of reg_pipeline: a valid bit, a WIDTH-bit data word and
//   (with REG_PIPE_PARITY_EN) a stored even-parity bit.
// Ports
//   clk, rst_n   rising-edge clock, async active-low reset (clears everything)
//   clear        sync clear of the valid bit; data/parity are left untouched
//   load         capture d_data (and d_par) and mark the stage valid
//   drain        contents move on this cycle; valid drops unless reloaded
//   d_data       incoming data word
//   d_par        incoming parity bit (REG_PIPE_PARITY_EN only)
//   valid_o      stage holds a beat
//   data_o       stored data word
//   par_o        stored parity bit (REG_PIPE_PARITY_EN only)
// Optional feature macro: REG_PIPE_PARITY_EN
// -----------------------------------------------------------------------------
module pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d_data,
`ifdef REG_PIPE_PARITY_EN
  input  logic             d_par,
  output logic             par_o,
`endif
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  stage_ctl_t       ctl_q, ctl_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next-state: clear beats load beats drain; a simultaneous load and drain
  // keeps the stage full with the new beat.
  always_comb begin
    ctl_d  = ctl_q;
    data_d = data_q;
    if (clear) begin
      ctl_d.valid = 1'b0;
    end else if (load) begin
      ctl_d.valid = 1'b1;
      data_d      = d_data;
`ifdef REG_PIPE_PARITY_EN
      ctl_d.par   = d_par;
`endif
    end else if (drain) begin
      ctl_d.valid = 1'b0;
    end else begin
      ctl_d  = ctl_q;
      data_d = data_q;
    end
  end

  // Stage state flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q  <= '0;
      data_q <= '0;
    end else begin
      ctl_q  <= ctl_d;
      data_q <= data_d;
    end
  end

  assign valid_o = ctl_q.valid;
  assign data_o  = data_q;
`ifdef REG_PIPE_PARITY_EN
  assign par_o   = ctl_q.par;
`endif

endmodule : pipe_stage

// File: rtl/reg_pipeline.sv
// -----------------------------------------------------------------------------
// reg_pipeline
//   Chain of DEPTH load-enabled registers with per-stage valid bits and a
//   valid/ready handshake at both ends. Bubbles collapse: a stage accepts new
//   data whenever it is empty or its current beat moves on in the same cycle.
//   The ready path is purely combinational through the chain (no skid buffer).
// Parameters
//   WIDTH  data bits per stage (>=1)
//   DEPTH  number of stages (>=1)
// Ports
//   clk, rst_n      rising-edge clock, async active-low reset
//   flush           sync clear of all valid bits (data regs keep their value)
//   in_valid/in_ready/in_data     upstream handshake
//   out_valid/out_ready/out_data  downstream handshake (last stage)
//   occupancy       number of valid stages (from the valid flops only)
//   out_parity_err  REG_PIPE_PARITY_EN only: last-stage parity mismatch
// Optional feature macro: REG_PIPE_PARITY_EN
// -----------------------------------------------------------------------------
module reg_pipeline
  import reg_pipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int OCC_W = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
`ifdef REG_PIPE_PARITY_EN
  ,
  output logic             out_parity_err
`endif
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("reg_pipeline: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] ready_s;
  logic [DEPTH-1:0] advance_s;
  logic [DEPTH-1:0] load_s;
  logic [WIDTH-1:0] data_s [DEPTH];
`ifdef REG_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_s;
`endif
  logic [OCC_W-1:0] occ_s;
  logic             all_v_s;

  // Ready chain. ready[k] = !valid[k] || ready[k+1], with out_ready past the
  // last stage, unrolls to "some stage k..DEPTH-1 is empty, or out_ready".
  // Computing it that way avoids a self-referencing vector in the loop.
  // A valid stage advances exactly when its own ready is high.
  always_comb begin
    ready_s   = '0;
    advance_s = '0;
    all_v_s   = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      all_v_s = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
        if (j >= k) begin
          all_v_s = all_v_s & valid_s[j];
        end else begin
          all_v_s = all_v_s;
        end
      end
      ready_s[k]   = !all_v_s || out_ready;
      advance_s[k] = valid_s[k] && ready_s[k];
    end
  end

  assign in_ready = ready_s[0] && !flush;

  // Stage instances and their load enables.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign load_s[k] = in_valid && in_ready;
    end else begin : g_rest
      assign load_s[k] = advance_s[k-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (flush),
      .load    (load_s[k]),
      .drain   (advance_s[k]),
      .d_data  ((k == 0) ? in_data : data_s[(k == 0) ? 0 : k-1]),
`ifdef REG_PIPE_PARITY_EN
      .d_par   ((k == 0) ? (^in_data) : par_s[(k == 0) ? 0 : k-1]),
      .par_o   (par_s[k]),
`endif
      .valid_o (valid_s[k]),
      .data_o  (data_s[k])
    );
  end

  // Occupancy is a popcount of the valid flops.
  always_comb begin
    occ_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_s = occ_s + OCC_W'(valid_s[k]);
    end
  end

  assign occupancy = occ_s;
  assign out_valid = valid_s[DEPTH-1];
  assign out_data  = data_s[DEPTH-1];

`ifdef REG_PIPE_PARITY_EN
  // Even parity: the stored bit equals the XOR of the data captured at stage 0.
  assign out_parity_err = out_valid && ((^out_data) != par_s[DEPTH-1]);
`endif

endmodule : reg_pipeline
